// File: rtl/alu_pipe_param_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Function codes and FSM encoding shared by the ALU files.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [3:0] c_fn_and    = 4'h0;
    localparam logic [3:0] c_fn_or     = 4'h1;
    localparam logic [3:0] c_fn_add    = 4'h2;
    localparam logic [3:0] c_fn_unused = 4'h3;
    localparam logic [3:0] c_fn_andn   = 4'h4;
    localparam logic [3:0] c_fn_orn    = 4'h5;
    localparam logic [3:0] c_fn_sub    = 4'h6;
    localparam logic [3:0] c_fn_slt    = 4'h7;
    localparam logic [3:0] c_fn_xor    = 4'h8;
    localparam logic [3:0] c_fn_xnor   = 4'h9;
    localparam logic [3:0] c_fn_lsl    = 4'hA;
    localparam logic [3:0] c_fn_lsr    = 4'hB;
    localparam logic [3:0] c_fn_sat    = 4'hC;
    localparam logic [3:0] c_fn_asr    = 4'hD;
    localparam logic [3:0] c_fn_rol    = 4'hE;
    localparam logic [3:0] c_fn_ror    = 4'hF;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic logic is_shift(input logic [3:0] fn);
        return (fn == c_fn_lsl) || (fn == c_fn_lsr) || (fn == c_fn_asr) ||
               (fn == c_fn_rol) || (fn == c_fn_ror);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_pipe_param_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe_param_if
// Description : Operand and result handshake bundle of the pipelined ALU.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_pipe_param_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       fin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Y;
    logic             flag_c;
    logic             flag_z;
    logic             flag_n;
    logic             flag_v;
    logic             flag_err;

    modport master (
        output in_valid, A, B, fin, out_ready,
        input  in_ready, out_valid, Y, flag_c, flag_z, flag_n, flag_v, flag_err
    );

    modport slave (
        input  in_valid, A, B, fin, out_ready,
        output in_ready, out_valid, Y, flag_c, flag_z, flag_n, flag_v, flag_err
    );
endinterface
`default_nettype wire

// File: rtl/alu_pipe_param_func_comb.sv
`default_nettype none
// ============================================================================
// Module      : alu_func_comb
// Description : Combinational function unit; barrel shifts when ITER_SHIFT=0.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_func_comb
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ITER_SHIFT = 1
) (
    input  wire logic [WIDTH-1:0] i_a,
    input  wire logic [WIDTH-1:0] i_b,
    input  wire logic [3:0]       i_fin,
    output logic      [WIDTH-1:0] o_y,
    output logic                  o_c,
    output logic                  o_v,
    output logic                  o_err
);
    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_lsl, w_lsr, w_asr, w_rol, w_ror;

    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    generate
        if (ITER_SHIFT == 0) begin : g_barrel
            logic [SHW-1:0]     w_k;
            logic [2*WIDTH-1:0] w_rl, w_rr;
            assign w_k   = i_b[SHW-1:0];
            // Rotates fall out of shifting a doubled copy of A.
            assign w_rl  = {i_a, i_a} << w_k;
            assign w_rr  = {i_a, i_a} >> w_k;
            assign w_lsl = i_a << w_k;
            assign w_lsr = i_a >> w_k;
            assign w_asr = $signed(i_a) >>> w_k;
            assign w_rol = w_rl[2*WIDTH-1:WIDTH];
            assign w_ror = w_rr[WIDTH-1:0];
        end else begin : g_iter
            // Only k=0 completes here; nonzero amounts run in the top-level shifter.
            assign w_lsl = i_a;
            assign w_lsr = i_a;
            assign w_asr = i_a;
            assign w_rol = i_a;
            assign w_ror = i_a;
        end
    endgenerate

    always_comb begin
        o_y   = '0;
        o_c   = 1'b0;
        o_v   = 1'b0;
        o_err = 1'b0;
        case (i_fin)
            c_fn_and:  o_y = i_a & i_b;
            c_fn_or:   o_y = i_a | i_b;
            c_fn_add: begin
                o_y = w_sum[WIDTH-1:0];
                o_c = w_sum[WIDTH];
                o_v = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
            end
            c_fn_unused: o_err = 1'b1;
            c_fn_andn: o_y = i_a & ~i_b;
            c_fn_orn:  o_y = i_a | ~i_b;
            c_fn_sub: begin
                o_y = w_diff[WIDTH-1:0];
                o_c = w_diff[WIDTH];
                o_v = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_a[WIDTH-1]);
            end
            c_fn_slt: begin
                o_y = {{(WIDTH-1){1'b0}}, w_diff[WIDTH]};
                o_c = w_diff[WIDTH];
            end
            c_fn_xor:  o_y = i_a ^ i_b;
            c_fn_xnor: o_y = ~(i_a ^ i_b);
            c_fn_lsl:  o_y = w_lsl;
            c_fn_lsr:  o_y = w_lsr;
            c_fn_sat: begin
                o_y = w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0];
                o_c = w_sum[WIDTH];
            end
            c_fn_asr:  o_y = w_asr;
            c_fn_rol:  o_y = w_rol;
            c_fn_ror:  o_y = w_ror;
            default:   o_y = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_pipe_param.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe_param
// Description : Registered ALU with valid/ready handshakes and optional
//               bit-serial shifter.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe_param
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ITER_SHIFT = 1
) (
    input  wire logic       clk,
    input  wire logic       rst,
    alu_pipe_param_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    state_t           r_state;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_work;
    logic [3:0]       r_op;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_y;
    logic             r_c, r_z, r_n, r_v, r_err;

    logic [SHW-1:0]   w_k;
    logic [WIDTH-1:0] w_fy, w_step, w_res_y;
    logic             w_fc, w_fv, w_ferr;
    logic             w_in_ready, w_accept, w_go_iter, w_drain_ok, w_done, w_load;

    alu_func_comb #(
        .WIDTH      (WIDTH),
        .ITER_SHIFT (ITER_SHIFT)
    ) u_func (
        .i_a   (bus.A),
        .i_b   (bus.B),
        .i_fin (bus.fin),
        .o_y   (w_fy),
        .o_c   (w_fc),
        .o_v   (w_fv),
        .o_err (w_ferr)
    );

    assign w_k        = bus.B[SHW-1:0];
    assign w_drain_ok = !r_out_valid || bus.out_ready;
    assign w_in_ready = (r_state == ST_IDLE) && w_drain_ok;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_go_iter  = (ITER_SHIFT != 0) && is_shift(bus.fin) && (w_k != '0);
    // A finished serial shift waits if the previous result is still unclaimed.
    assign w_done     = (r_state == ST_SHIFT) && (r_cnt == SHW'(1)) && w_drain_ok;
    assign w_load     = (w_accept && !w_go_iter) || w_done;
    assign w_res_y    = (r_state == ST_SHIFT) ? w_step : w_fy;

    always_comb begin
        w_step = r_work;
        case (r_op)
            c_fn_lsl: w_step = {r_work[WIDTH-2:0], 1'b0};
            c_fn_lsr: w_step = {1'b0, r_work[WIDTH-1:1]};
            c_fn_asr: w_step = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
            c_fn_rol: w_step = {r_work[WIDTH-2:0], r_work[WIDTH-1]};
            c_fn_ror: w_step = {r_work[0], r_work[WIDTH-1:1]};
            default:  w_step = r_work;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_work      <= '0;
            r_op        <= '0;
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_c         <= 1'b0;
            r_z         <= 1'b0;
            r_n         <= 1'b0;
            r_v         <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_go_iter) begin
                        r_state <= ST_SHIFT;
                        r_work  <= bus.A;
                        r_cnt   <= w_k;
                        r_op    <= bus.fin;
                    end
                end
                ST_SHIFT: begin
                    if (r_cnt == SHW'(1)) begin
                        if (w_drain_ok) begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                        end
                    end else begin
                        r_work <= w_step;
                        r_cnt  <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_y         <= w_res_y;
                r_z         <= (w_res_y == '0);
                r_n         <= w_res_y[WIDTH-1];
                r_c         <= (r_state == ST_IDLE) && w_fc;
                r_v         <= (r_state == ST_IDLE) && w_fv;
                r_err       <= (r_state == ST_IDLE) && w_ferr;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.Y         = r_y;
    assign bus.flag_c    = r_c;
    assign bus.flag_z    = r_z;
    assign bus.flag_n    = r_n;
    assign bus.flag_v    = r_v;
    assign bus.flag_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_pipe_param
// Description : Self-checking bench: 32-bit serial-shift ALU plus 8-bit barrel build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_pipe_param;
    import alu_pkg::*;

    typedef struct packed {
        logic [31:0] y;
        logic        c;
        logic        v;
        logic        err;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  fin;
        exp_t        e;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];
    int   pop_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_pipe_param_if #(.WIDTH(32)) if32 ();
    alu_pipe_param_if #(.WIDTH(8))  if8 ();

    alu_pipe_param #(.WIDTH(32), .ITER_SHIFT(1)) dut32 (.clk(clk), .rst(rst), .bus(if32.slave));
    alu_pipe_param #(.WIDTH(8),  .ITER_SHIFT(0)) dut8  (.clk(clk), .rst(rst), .bus(if8.slave));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every transfer on the output side is compared with the oldest expectation.
    always @(negedge clk) begin
        #1;
        if (if32.out_valid === 1'b1 && if32.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got Y=%h with no expectation queued", if32.Y);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", {27'd0, if32.Y, if32.flag_c, if32.flag_z, if32.flag_n, if32.flag_v, if32.flag_err},
                      {27'd0, e.y, e.c, (e.y == 32'd0), e.y[31], e.v, e.err});
                pop_cyc.push_back(cyc);
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] f,
                        input exp_t e, input bit push, output int waits);
        @(negedge clk);
        if32.in_valid = 1'b1;
        if32.A = a;
        if32.B = b;
        if32.fin = f;
        waits = 0;
        #1;
        while (if32.in_ready !== 1'b1 && waits < 200) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (waits >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready still %b after %0d cycles", if32.in_ready, waits);
            if32.in_valid = 1'b0;
        end else begin
            if (push) sb.push_back(e);
            @(posedge clk);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        if32.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue_empty", 64'(sb.size()), 64'd0);
    endtask

    // Serial shift: in_ready must stay low exactly k cycles, then the result shows up.
    task automatic serial_seq(input logic [31:0] a, input logic [31:0] b, input logic [3:0] f,
                              input logic [31:0] y, input int k);
        int w;
        int low;
        send(a, b, f, '{y: y, c: 1'b0, v: 1'b0, err: 1'b0}, 1'b1, w);
        @(negedge clk);
        if32.in_valid = 1'b0;
        #1;
        low = 0;
        while (if32.in_ready !== 1'b1 && low < 60) begin
            low++;
            @(negedge clk);
            #1;
        end
        check("serial_ready_low_cycles", 64'(low), 64'(k));
        check("serial_valid_at_ready", 64'(if32.out_valid), 64'd1);
        drain();
    endtask

    task automatic chk8(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] f, input logic [7:0] y, input logic c);
        @(negedge clk);
        if8.in_valid = 1'b1;
        if8.A = a;
        if8.B = b;
        if8.fin = f;
        #1;
        check({name, "_ready"}, 64'(if8.in_ready), 64'd1);
        @(negedge clk);
        if8.in_valid = 1'b0;
        #1;
        check(name, {55'd0, if8.out_valid, if8.Y}, {55'd0, 1'b1, y});
        check({name, "_c"}, 64'(if8.flag_c), 64'(c));
    endtask

    vec_t vecs[23];

    initial begin
        int w;
        int seen;
        logic [31:0] ra, rb;
        exp_t e;

        vecs[0]  = '{32'hFFFFFFFF, 32'h00000001, c_fn_add,    '{32'h00000000, 1'b1, 1'b0, 1'b0}};
        vecs[1]  = '{32'h80000000, 32'h00000001, c_fn_sub,    '{32'h7FFFFFFF, 1'b0, 1'b1, 1'b0}};
        vecs[2]  = '{32'hF0F0F0F0, 32'h0FF00FF0, c_fn_and,    '{32'h00F000F0, 1'b0, 1'b0, 1'b0}};
        vecs[3]  = '{32'h12340000, 32'h00005678, c_fn_or,     '{32'h12345678, 1'b0, 1'b0, 1'b0}};
        vecs[4]  = '{32'hFFFF0000, 32'h0F0F0F0F, c_fn_andn,   '{32'hF0F00000, 1'b0, 1'b0, 1'b0}};
        vecs[5]  = '{32'h00000000, 32'hFFFFFFFE, c_fn_orn,    '{32'h00000001, 1'b0, 1'b0, 1'b0}};
        vecs[6]  = '{32'hAAAAAAAA, 32'h55555555, c_fn_xor,    '{32'hFFFFFFFF, 1'b0, 1'b0, 1'b0}};
        vecs[7]  = '{32'h12345678, 32'h12345678, c_fn_xnor,   '{32'hFFFFFFFF, 1'b0, 1'b0, 1'b0}};
        vecs[8]  = '{32'h00000003, 32'h00000005, c_fn_slt,    '{32'h00000001, 1'b1, 1'b0, 1'b0}};
        vecs[9]  = '{32'h00000005, 32'h00000003, c_fn_slt,    '{32'h00000000, 1'b0, 1'b0, 1'b0}};
        vecs[10] = '{32'h00000005, 32'h00000006, c_fn_unused, '{32'h00000000, 1'b0, 1'b0, 1'b1}};
        vecs[11] = '{32'hFFFFFFF0, 32'h00000020, c_fn_sat,    '{32'hFFFFFFFF, 1'b1, 1'b0, 1'b0}};
        vecs[12] = '{32'h00000001, 32'h00000002, c_fn_sat,    '{32'h00000003, 1'b0, 1'b0, 1'b0}};
        vecs[13] = '{32'h80000001, 32'h00000001, c_fn_rol,    '{32'h00000003, 1'b0, 1'b0, 1'b0}};
        vecs[14] = '{32'h80000000, 32'h00000004, c_fn_asr,    '{32'hF8000000, 1'b0, 1'b0, 1'b0}};
        vecs[15] = '{32'h00000001, 32'h0000001F, c_fn_lsl,    '{32'h80000000, 1'b0, 1'b0, 1'b0}};
        vecs[16] = '{32'h80000000, 32'h0000001F, c_fn_lsr,    '{32'h00000001, 1'b0, 1'b0, 1'b0}};
        vecs[17] = '{32'h00000001, 32'h00000004, c_fn_ror,    '{32'h10000000, 1'b0, 1'b0, 1'b0}};
        vecs[18] = '{32'h00001234, 32'h00000000, c_fn_lsl,    '{32'h00001234, 1'b0, 1'b0, 1'b0}};
        vecs[19] = '{32'h7FFFFFFF, 32'h00000001, c_fn_add,    '{32'h80000000, 1'b0, 1'b1, 1'b0}};
        vecs[20] = '{32'h00000005, 32'h00000005, c_fn_sub,    '{32'h00000000, 1'b0, 1'b0, 1'b0}};
        vecs[21] = '{32'h000000F0, 32'h00000124, c_fn_lsr,    '{32'h0000000F, 1'b0, 1'b0, 1'b0}};
        vecs[22] = '{32'h12345678, 32'h00000008, c_fn_rol,    '{32'h34567812, 1'b0, 1'b0, 1'b0}};

        if32.in_valid = 1'b0; if32.A = '0; if32.B = '0; if32.fin = '0; if32.out_ready = 1'b1;
        if8.in_valid  = 1'b0; if8.A  = '0; if8.B  = '0; if8.fin  = '0; if8.out_ready  = 1'b1;

        repeat (3) @(negedge clk);
        #1;
        check("reset_out32", {26'd0, if32.out_valid, if32.Y, if32.flag_c, if32.flag_z,
                              if32.flag_n, if32.flag_v, if32.flag_err}, 64'd0);
        check("reset_out8", {50'd0, if8.out_valid, if8.Y, if8.flag_c, if8.flag_z,
                             if8.flag_n, if8.flag_v, if8.flag_err}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("ready_after_reset", 64'(if32.in_ready), 64'd1);

        // Table vectors issued back-to-back; serial shifts stall the stream naturally.
        foreach (vecs[i]) send(vecs[i].a, vecs[i].b, vecs[i].fin, vecs[i].e, 1'b1, w);
        idle();
        drain();

        serial_seq(32'h80000000, 32'h00000004, c_fn_asr, 32'hF8000000, 4);
        serial_seq(32'h80000001, 32'h00000001, c_fn_rol, 32'h00000003, 1);

        // Eight single-cycle ops must drain on eight consecutive cycles.
        pop_cyc.delete();
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = $urandom;
            e  = '{y: (i % 2 == 0) ? (ra & rb) : (ra ^ rb), c: 1'b0, v: 1'b0, err: 1'b0};
            send(ra, rb, (i % 2 == 0) ? c_fn_and : c_fn_xor, e, 1'b1, w);
            check("b2b_no_stall", 64'(w), 64'd0);
        end
        idle();
        drain();
        check("b2b_count", 64'(pop_cyc.size()), 64'd8);
        for (int i = 1; i < pop_cyc.size(); i++) begin
            check("b2b_consecutive", 64'(pop_cyc[i] - pop_cyc[0]), 64'(i));
        end

        // Backpressure: the result must hold while the consumer stalls.
        if32.out_ready = 1'b0;
        send(32'hFFFFFFF0, 32'h00000020, c_fn_sat, '{32'hFFFFFFFF, 1'b1, 1'b0, 1'b0}, 1'b1, w);
        idle();
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_hold", {29'd0, if32.out_valid, if32.Y, if32.flag_c, if32.in_ready},
                  {29'd0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0});
            @(negedge clk);
        end
        if32.out_ready = 1'b1;
        #1;
        check("bp_ready_on_release", 64'(if32.in_ready), 64'd1);
        drain();

        // Reset in the third cycle of a 10-step shift discards it.
        send(32'h00000001, 32'h0000000A, c_fn_lsl, '{32'h0, 1'b0, 1'b0, 1'b0}, 1'b0, w);
        @(negedge clk);
        if32.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("midshift_reset", {30'd0, if32.out_valid, if32.Y, if32.in_ready},
              {30'd0, 1'b0, 32'd0, 1'b1});
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (if32.out_valid === 1'b1) seen++;
        end
        check("no_stale_result", 64'(seen), 64'd0);

        // 8-bit barrel-shift build.
        chk8("w8_lsr", 8'h80, 8'h07, c_fn_lsr, 8'h01, 1'b0);
        chk8("w8_rol", 8'h81, 8'h01, c_fn_rol, 8'h03, 1'b0);
        chk8("w8_asr", 8'h80, 8'h03, c_fn_asr, 8'hF0, 1'b0);
        chk8("w8_ror", 8'h01, 8'h01, c_fn_ror, 8'h80, 1'b0);
        chk8("w8_lsl_kmask", 8'h01, 8'h0B, c_fn_lsl, 8'h08, 1'b0);
        chk8("w8_add", 8'hFF, 8'h01, c_fn_add, 8'h00, 1'b1);
        chk8("w8_sub", 8'h80, 8'h01, c_fn_sub, 8'h7F, 1'b0);

        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
